// File: rtl/poly_eval_horner_pkg.sv
// Shared Q4.15 constants, FSM state type and coefficient conversion for the
// Horner polynomial evaluator and the solver datapath.
package poly_pkg;

    localparam int W    = 20;
    localparam int FRAC = 15;
    localparam int DEG  = 8;
    localparam int CW   = 3;
    localparam int KW   = 4;

    localparam logic [W-1:0] QMAX = 20'h7FFFF;
    localparam logic [W-1:0] QMIN = 20'h80000;
    localparam logic [W-1:0] ONE  = 20'h08000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Small signed integer coefficient to Q4.15 (|c| <= 4 always fits)
    function automatic logic signed [W-1:0] coef_to_fix(input logic signed [CW-1:0] c);
        logic signed [W-1:0] ext;
        ext = {{(W-CW){c[CW-1]}}, c};
        return ext <<< FRAC;
    endfunction

endpackage

// File: rtl/poly_eval_horner_if.sv
// Operand/result valid-ready bus of the polynomial evaluator.
interface poly_eval_horner_if;
    import poly_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            x;
    logic [(DEG+1)*CW-1:0]   coef;
    logic                    out_valid;
    logic                    out_ready;
    logic [W-1:0]            fx;
    logic                    ovf;

    modport master (
        output in_valid, x, coef, out_ready,
        input  in_ready, out_valid, fx, ovf
    );

    modport slave (
        input  in_valid, x, coef, out_ready,
        output in_ready, out_valid, fx, ovf
    );

endinterface

// File: rtl/poly_eval_horner_fx_mul_q.sv
// Combinational signed Q4.15 multiply with floor rescale and a flag that is
// set when the rescaled product does not fit in W signed bits.
module fx_mul_q
    import poly_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] q,
    output logic                ovf
);

    logic signed [2*W-1:0] p_s;
    logic signed [2*W-1:0] sh_s;

    // Full-width product, arithmetic rescale, and fit check on the upper bits
    always_comb begin
        p_s  = a * b;
        sh_s = p_s >>> FRAC;
        q    = sh_s[W-1:0];
        ovf  = !((&sh_s[2*W-1:W-1]) || !(|sh_s[2*W-1:W-1]));
    end

endmodule

// File: rtl/poly_eval_horner.sv
// Sequential Horner evaluator f(x) = c0 + c1*x + ... + c8*x^8 in Q4.15.
// Build option POLY_SAT_EN: saturate the accumulator on a step overflow.
module poly_eval_horner
    import poly_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    poly_eval_horner_if.slave   bus
);

    state_e                  state_q, state_d;
    logic signed [W-1:0]     acc_q, acc_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [W-1:0]     x_q, x_d;
    logic [(DEG+1)*CW-1:0]   coef_q, coef_d;
    logic                    ovf_int_q, ovf_int_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [W-1:0]            fx_q, fx_d;
    logic                    ovf_q, ovf_d;

    logic signed [W-1:0]     mq_s;
    logic                    m_ovf_s;
    logic signed [CW-1:0]    ck_s;
    logic signed [W-1:0]     cfix_s;
    logic [W:0]              sum_s;
    logic                    step_ovf_s;
    logic signed [W-1:0]     step_acc_s;
`ifdef POLY_SAT_EN
    logic                    true_neg_s;
`endif

    fx_mul_q u_mul (
        .a   (acc_q),
        .b   (x_q),
        .q   (mq_s),
        .ovf (m_ovf_s)
    );

    // One Horner step: acc*x rescaled plus the current coefficient
    always_comb begin
        ck_s       = coef_q[int'(k_q)*CW +: CW];
        cfix_s     = coef_to_fix(ck_s);
        sum_s      = {mq_s[W-1], mq_s} + {cfix_s[W-1], cfix_s};
        step_ovf_s = m_ovf_s | (sum_s[W] ^ sum_s[W-1]);
`ifdef POLY_SAT_EN
        // A product overflow dominates the sign; the coefficient cannot flip it
        if (step_ovf_s) begin
            true_neg_s = m_ovf_s ? (acc_q[W-1] ^ x_q[W-1]) : sum_s[W];
            step_acc_s = true_neg_s ? QMIN : QMAX;
        end else begin
            true_neg_s = 1'b0;
            step_acc_s = sum_s[W-1:0];
        end
`else
        step_acc_s = sum_s[W-1:0];
`endif
    end

    // Next-state and registered-output logic of the IDLE/MAC/DONE sequencer
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        k_d         = k_q;
        x_d         = x_q;
        coef_d      = coef_q;
        ovf_int_d   = ovf_int_q;
        out_valid_d = out_valid_q;
        fx_d        = fx_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d       = bus.x;
                    coef_d    = bus.coef;
                    acc_d     = coef_to_fix(bus.coef[DEG*CW +: CW]);
                    k_d       = KW'(DEG - 1);
                    ovf_int_d = 1'b0;
                    state_d   = ST_MAC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d     = step_acc_s;
                ovf_int_d = ovf_int_q | step_ovf_s;
                if (k_q == {KW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q - {{(KW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                fx_d        = acc_q;
                ovf_d       = ovf_int_q;
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any evaluation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {W{1'b0}};
            k_q         <= {KW{1'b0}};
            x_q         <= {W{1'b0}};
            coef_q      <= {((DEG+1)*CW){1'b0}};
            ovf_int_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fx_q        <= {W{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
            ovf_int_q   <= ovf_int_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            fx_q        <= fx_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fx        = fx_q;
    assign bus.ovf       = ovf_q;

endmodule
